// File: rtl/multicycle_controller.sv
// Main sequencing FSM of the multi-cycle RV32I-subset core: drives every datapath
// enable and mux select from the current state and the instruction register fields.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8,
  parameter bit          EN_LUI      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic       func7_5,
  input  logic       zero,
  input  logic       neg,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_MEM_WB    = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR_ADDR = 4'd11,
    S_JALR_JUMP = 4'd12,
    S_LUI       = 4'd13,
    S_ILLEGAL   = 4'd14,
    S_BUS_ERR   = 4'd15
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              illegal_q, bus_err_q;

  logic              waitState, toHit;
  logic [2:0]        aluFn;
  logic              fnOk;
  logic              taken, brOk;
  logic              pcWr, adrSel, memWr, irWr, regWr;
  logic [1:0]        resSel, srcA, srcB;
  logic [2:0]        aluCtl;

  assign waitState = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  assign toHit     = (MEM_TIMEOUT != 0) && waitState && (cnt_q == TO_LIMIT);

  always_comb begin
    aluFn = ALU_ADD;
    fnOk  = 1'b1;
    case (func3)
      3'b000:  aluFn = (state_q == S_EXEC_R && func7_5) ? ALU_SUB : ALU_ADD;
      3'b111:  aluFn = ALU_AND;
      3'b110:  aluFn = ALU_OR;
      3'b100:  aluFn = ALU_XOR;
      3'b010:  aluFn = ALU_SLT;
      default: fnOk  = 1'b0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    brOk  = 1'b1;
    case (func3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = neg;
      3'b101:  taken = !neg;
      default: brOk  = 1'b0;
    endcase
  end

  always_comb begin
    imm_src = 3'b000;
    case (op)
      OP_STORE:  imm_src = 3'b001;
      OP_BRANCH: imm_src = 3'b010;
      OP_LUI:    imm_src = 3'b011;
      OP_JAL:    imm_src = 3'b100;
      default:   imm_src = 3'b000;
    endcase
  end

  // Next state plus the per-state datapath controls; wait states either complete,
  // count another stalled cycle, or abort to BUS_ERR once the stall budget is spent.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    pcWr    = 1'b0;
    adrSel  = 1'b0;
    memWr   = 1'b0;
    irWr    = 1'b0;
    regWr   = 1'b0;
    resSel  = 2'b00;
    srcA    = 2'b00;
    srcB    = 2'b00;
    aluCtl  = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        srcB   = 2'b10;
        resSel = 2'b10;
        if (toHit) begin
          state_d = S_BUS_ERR;
        end else if (mem_ready) begin
          pcWr    = 1'b1;
          irWr    = 1'b1;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_DECODE: begin
        srcA = 2'b01;
        srcB = 2'b01;
        case (op)
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR_ADDR;
          OP_LUI:            state_d = EN_LUI ? S_LUI : S_ILLEGAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        srcA    = 2'b10;
        srcB    = (state_q == S_EXEC_I) ? 2'b01 : 2'b00;
        aluCtl  = aluFn;
        state_d = fnOk ? S_ALU_WB : S_ILLEGAL;
      end
      S_MEM_ADDR: begin
        srcA    = 2'b10;
        srcB    = 2'b01;
        state_d = (op == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        adrSel = 1'b1;
        if (toHit) begin
          state_d = S_BUS_ERR;
        end else if (mem_ready) begin
          state_d = S_MEM_WB;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_MEM_WB: begin
        resSel  = 2'b01;
        regWr   = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_WRITE: begin
        adrSel = 1'b1;
        if (toHit) begin
          state_d = S_BUS_ERR;
        end else begin
          memWr = 1'b1;
          if (mem_ready) begin
            state_d = S_FETCH;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
      end
      S_ALU_WB: begin
        regWr   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        srcA    = 2'b10;
        aluCtl  = ALU_SUB;
        pcWr    = brOk && taken;
        state_d = brOk ? S_FETCH : S_ILLEGAL;
      end
      S_JAL, S_JALR_JUMP: begin
        pcWr    = 1'b1;
        srcA    = 2'b01;
        srcB    = 2'b10;
        state_d = S_ALU_WB;
      end
      S_JALR_ADDR: begin
        srcA    = 2'b10;
        srcB    = 2'b01;
        state_d = S_JALR_JUMP;
      end
      S_LUI: begin
        resSel  = 2'b11;
        regWr   = 1'b1;
        state_d = S_FETCH;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      S_BUS_ERR: state_d = S_BUS_ERR;
      default:   state_d = S_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_d == S_ILLEGAL) illegal_q <= 1'b1;
      if (state_d == S_BUS_ERR) bus_err_q <= 1'b1;
    end
  end

  // Strobes are gated by rst_n so nothing can commit while reset is held,
  // even the FETCH strobes that follow mem_ready combinationally.
  assign pc_write    = pcWr & rst_n;
  assign ir_write    = irWr & rst_n;
  assign mem_write   = memWr & rst_n;
  assign reg_write   = regWr & rst_n;
  assign adr_src     = adrSel;
  assign result_src  = resSel;
  assign alu_src_a   = srcA;
  assign alu_src_b   = srcB;
  assign alu_control = aluCtl;
  assign illegal     = illegal_q;
  assign bus_err     = bus_err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed scenarios plus random instruction streams,
// checked every cycle against an instruction-level plan model of the sequencing.
module tb_multicycle_controller;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'b0110011;
  logic [2:0] func3 = 3'b000;
  logic       func7_5 = 1'b0;
  logic       zero = 1'b0;
  logic       neg = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal, bus_err;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(TO), .TO_W(8), .EN_LUI(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func3(func3), .func7_5(func7_5),
    .zero(zero), .neg(neg), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
    .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  // Debug state numbering follows the order the states are listed in the design.
  typedef enum int {
    P_FETCH = 0, P_DECODE = 1, P_EXEC_R = 2, P_EXEC_I = 3, P_MEM_ADDR = 4, P_MEM_READ = 5,
    P_MEM_WB = 6, P_MEM_WRITE = 7, P_ALU_WB = 8, P_BRANCH = 9, P_JAL = 10, P_JALR_ADDR = 11,
    P_JALR_JUMP = 12, P_LUI = 13, P_ILLEGAL = 14, P_BUS_ERR = 15
  } phase_e;

  phase_e cur = P_FETCH;
  phase_e plan[$];
  int     waitCnt = 0;
  int     errors = 0;
  int     checks = 0;
  int     cycle = 0;

  logic       smpPc, smpAdr, smpMw, smpIr, smpRw, smpIll, smpBe;
  logic [1:0] smpRes;
  logic [2:0] smpAlu, smpImm;

  logic [6:0] opTable [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                              7'b1101111, 7'b1100111, 7'b0110111, 7'b1111111};
  logic [2:0] aluF3 [5] = '{3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
  logic [2:0] brF3 [4]  = '{3'b000, 3'b001, 3'b100, 3'b101};

  function automatic bit aluOk(input logic [2:0] f);
    return f inside {3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
  endfunction

  function automatic bit brOk(input logic [2:0] f);
    return f inside {3'b000, 3'b001, 3'b100, 3'b101};
  endfunction

  function automatic logic [2:0] aluFor(input logic [2:0] f, input logic f75, input bit allowSub);
    case (f)
      3'b000:  return (allowSub && f75) ? 3'd1 : 3'd0;
      3'b111:  return 3'd2;
      3'b110:  return 3'd3;
      3'b100:  return 3'd4;
      3'b010:  return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic branchTaken(input logic [2:0] f, input logic z, input logic n);
    case (f)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n;
      3'b101:  return !n;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] immFor(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'd1;
      7'b1100011: return 3'd2;
      7'b0110111: return 3'd3;
      7'b1101111: return 3'd4;
      default:    return 3'd0;
    endcase
  endfunction

  // The whole post-fetch route of an instruction is fixed by its encoding alone.
  function automatic void buildPlan();
    plan.delete();
    plan.push_back(P_DECODE);
    case (op)
      7'b0110011: begin plan.push_back(P_EXEC_R); plan.push_back(aluOk(func3) ? P_ALU_WB : P_ILLEGAL); end
      7'b0010011: begin plan.push_back(P_EXEC_I); plan.push_back(aluOk(func3) ? P_ALU_WB : P_ILLEGAL); end
      7'b0000011: begin plan.push_back(P_MEM_ADDR); plan.push_back(P_MEM_READ); plan.push_back(P_MEM_WB); end
      7'b0100011: begin plan.push_back(P_MEM_ADDR); plan.push_back(P_MEM_WRITE); end
      7'b1100011: begin plan.push_back(P_BRANCH); if (!brOk(func3)) plan.push_back(P_ILLEGAL); end
      7'b1101111: begin plan.push_back(P_JAL); plan.push_back(P_ALU_WB); end
      7'b1100111: begin plan.push_back(P_JALR_ADDR); plan.push_back(P_JALR_JUMP); plan.push_back(P_ALU_WB); end
      7'b0110111: plan.push_back(P_LUI);
      default:    plan.push_back(P_ILLEGAL);
    endcase
  endfunction

  function automatic phase_e nextFromPlan();
    return (plan.size() != 0) ? plan.pop_front() : P_FETCH;
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d phase=%s: got %0d, expected %0d", name, cycle, cur.name(), actual, expected);
    end
  endtask

  task automatic compareModel();
    logic       ePc = 0, eAdr = 0, eMw = 0, eIr = 0, eRw = 0;
    logic [1:0] eRes = 0, eA = 0, eB = 0;
    logic [2:0] eAlu = 0;
    bit         toHit = (TO != 0) && (waitCnt == TO);
    case (cur)
      P_FETCH:     begin eB = 2; eRes = 2; ePc = mem_ready && !toHit; eIr = mem_ready && !toHit; end
      P_DECODE:    begin eA = 1; eB = 1; end
      P_EXEC_R:    begin eA = 2; eB = 0; eAlu = aluFor(func3, func7_5, 1); end
      P_EXEC_I:    begin eA = 2; eB = 1; eAlu = aluFor(func3, func7_5, 0); end
      P_MEM_ADDR:  begin eA = 2; eB = 1; end
      P_MEM_READ:  eAdr = 1;
      P_MEM_WB:    begin eRes = 1; eRw = 1; end
      P_MEM_WRITE: begin eAdr = 1; eMw = !toHit; end
      P_ALU_WB:    eRw = 1;
      P_BRANCH:    begin eA = 2; eAlu = 1; ePc = branchTaken(func3, zero, neg); end
      P_JAL, P_JALR_JUMP: begin ePc = 1; eA = 1; eB = 2; end
      P_JALR_ADDR: begin eA = 2; eB = 1; end
      P_LUI:       begin eRes = 3; eRw = 1; end
      default:     ;
    endcase
    checkOutput("pc_write", pc_write, ePc);
    checkOutput("adr_src", adr_src, eAdr);
    checkOutput("mem_write", mem_write, eMw);
    checkOutput("ir_write", ir_write, eIr);
    checkOutput("reg_write", reg_write, eRw);
    checkOutput("result_src", result_src, eRes);
    checkOutput("alu_src_a", alu_src_a, eA);
    checkOutput("alu_src_b", alu_src_b, eB);
    checkOutput("alu_control", alu_control, eAlu);
    checkOutput("imm_src", imm_src, immFor(op));
    checkOutput("illegal", illegal, cur == P_ILLEGAL);
    checkOutput("bus_err", bus_err, cur == P_BUS_ERR);
    checkOutput("state", state, 4'(int'(cur)));
  endtask

  task automatic advanceModel();
    bit toHit = (TO != 0) && (waitCnt == TO);
    case (cur)
      P_FETCH, P_MEM_READ, P_MEM_WRITE: begin
        if (toHit) begin
          cur = P_BUS_ERR;
          waitCnt = 0;
        end else if (mem_ready) begin
          waitCnt = 0;
          if (cur == P_FETCH) buildPlan();
          cur = nextFromPlan();
        end else begin
          waitCnt++;
        end
      end
      P_ILLEGAL, P_BUS_ERR: ;
      default: cur = nextFromPlan();
    endcase
  endtask

  // One clock cycle: drive just after the rising edge, sample and compare on the falling edge.
  task automatic applyStimulus(input logic rdy, input logic z, input logic n);
    mem_ready = rdy;
    zero = z;
    neg = n;
    @(negedge clk);
    cycle++;
    smpPc = pc_write; smpAdr = adr_src; smpMw = mem_write; smpIr = ir_write; smpRw = reg_write;
    smpIll = illegal; smpBe = bus_err; smpRes = result_src; smpAlu = alu_control; smpImm = imm_src;
    compareModel();
    advanceModel();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_pc_write", pc_write, 0);
    checkOutput("rst_ir_write", ir_write, 0);
    checkOutput("rst_mem_write", mem_write, 0);
    checkOutput("rst_reg_write", reg_write, 0);
    checkOutput("rst_illegal", illegal, 0);
    checkOutput("rst_bus_err", bus_err, 0);
    checkOutput("rst_state", state, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cur = P_FETCH;
    plan.delete();
    waitCnt = 0;
  endtask

  task automatic setInstr(input logic [6:0] o, input logic [2:0] f3, input logic f75);
    op = o;
    func3 = f3;
    func7_5 = f75;
  endtask

  task automatic pickInstr();
    op = opTable[$urandom_range(0, 8)];
    func3 = 3'($urandom_range(0, 7));
    func7_5 = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) != 0) begin
      if (op == 7'b1100011) func3 = brF3[$urandom_range(0, 3)];
      else if (op == 7'b0110011 || op == 7'b0010011) func3 = aluF3[$urandom_range(0, 4)];
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;
    applyReset();

    // add, then sub: four cycles, write-back only in the last
    setInstr(7'b0110011, 3'b000, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(1, 0, 0);
      if (c == 3) checkOutput("add_alu_control", smpAlu, 3'd0);
      checkOutput("add_reg_write", smpRw, (c == 4));
    end
    setInstr(7'b0110011, 3'b000, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(1, 0, 0);
      if (c == 3) checkOutput("sub_alu_control", smpAlu, 3'd1);
    end

    // lw with three stalled MEM_READ cycles
    setInstr(7'b0000011, 3'b010, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(!(c >= 4 && c <= 6), 0, 0);
      if (c >= 4 && c <= 7) checkOutput("lw_wait_adr_src", smpAdr, 1);
      if (c == 5) checkOutput("lw_wait_reg_write", smpRw, 0);
      if (c == 8) begin
        checkOutput("lw_wb_reg_write", smpRw, 1);
        checkOutput("lw_wb_result_src", smpRes, 2'b01);
      end
    end

    // branches: beq taken/not taken, blt taken, bge not taken
    setInstr(7'b1100011, 3'b000, 1'b0);
    applyStimulus(1, 0, 0); applyStimulus(1, 0, 0); applyStimulus(1, 1, 0);
    checkOutput("beq_z1_pc_write", smpPc, 1);
    applyStimulus(1, 0, 0); applyStimulus(1, 0, 0); applyStimulus(1, 0, 0);
    checkOutput("beq_z0_pc_write", smpPc, 0);
    setInstr(7'b1100011, 3'b100, 1'b0);
    applyStimulus(1, 0, 0); applyStimulus(1, 0, 0); applyStimulus(1, 0, 1);
    checkOutput("blt_n1_pc_write", smpPc, 1);
    setInstr(7'b1100011, 3'b101, 1'b0);
    applyStimulus(1, 0, 0); applyStimulus(1, 0, 0); applyStimulus(1, 0, 1);
    checkOutput("bge_n1_pc_write", smpPc, 0);

    // jalr: jump in cycle 4, link write in cycle 5
    setInstr(7'b1100111, 3'b000, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(1, 0, 0);
      if (c == 4) checkOutput("jalr_jump_pc_write", smpPc, 1);
      if (c == 5) checkOutput("jalr_link_reg_write", smpRw, 1);
    end

    // lui: three cycles, immediate written back
    setInstr(7'b0110111, 3'b000, 1'b0);
    for (int c = 1; c <= 3; c++) applyStimulus(1, 0, 0);
    checkOutput("lui_result_src", smpRes, 2'b11);
    checkOutput("lui_imm_src", smpImm, 3'b011);

    // branch with func3 010 is illegal and never redirects the PC
    setInstr(7'b1100011, 3'b010, 1'b0);
    applyStimulus(1, 0, 0); applyStimulus(1, 0, 0); applyStimulus(1, 1, 0);
    checkOutput("bad_branch_pc_write", smpPc, 0);
    applyStimulus(1, 0, 0);
    checkOutput("bad_branch_illegal", smpIll, 1);
    applyReset();

    // unsupported opcode: terminal ILLEGAL until reset
    setInstr(7'b1111111, 3'b000, 1'b0);
    applyStimulus(1, 0, 0); applyStimulus(1, 0, 0);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checkOutput("ill_sticky", smpIll, 1);
    end
    applyReset();
    applyStimulus(0, 0, 0);
    checkOutput("ill_cleared", smpIll, 0);
    applyReset();

    // sw with mem_ready stuck low: four write cycles, then the timeout cycle, then BUS_ERR
    setInstr(7'b0100011, 3'b010, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(c <= 3, 0, 0);
      if (c >= 4 && c <= 7) checkOutput("sw_to_mem_write", smpMw, 1);
      if (c == 8) checkOutput("sw_to_strobe_off", smpMw, 0);
      if (c >= 9) checkOutput("sw_to_bus_err", smpBe, 1);
    end
    applyReset();

    // sw again, reset dropped inside MEM_WRITE
    setInstr(7'b0100011, 3'b010, 1'b0);
    for (int c = 1; c <= 4; c++) applyStimulus(c <= 3, 0, 0);
    #1;
    checkOutput("sw_mw_before_rst", mem_write, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("sw_mw_async_drop", mem_write, 0);
    applyReset();

    // random instruction streams
    for (int i = 0; i < 2000; i++) begin
      if (cur == P_FETCH && waitCnt == 0) pickInstr();
      if ((cur == P_ILLEGAL || cur == P_BUS_ERR) && $urandom_range(0, 3) == 0) applyReset();
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
